// File: rtl/fir_sterownik_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_sterownik_if
// Brief    : Handshake, memory-address and accumulator-strobe bundle of the
//            FIR control FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_sterownik_if #(
  parameter int ADDR_W = 4
);
  logic              probka_valid;
  logic              probka_ready;
  logic              zapis_probki;
  logic [ADDR_W-1:0] adres_zapisu;
  logic [ADDR_W-1:0] adres_odczytu;
  logic [ADDR_W-1:0] adres_wsp;
  logic              FSM_reset_Acc;
  logic              FSM_Acc_en;
  logic              FSM_Acc_zapis;
  logic              wynik_valid;
  logic              busy;
  logic              blad_przepelnienia;

  modport master (
    input  probka_valid,
    output probka_ready, zapis_probki, adres_zapisu, adres_odczytu, adres_wsp,
    output FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, wynik_valid, busy,
    output blad_przepelnienia
  );

  modport slave (
    output probka_valid,
    input  probka_ready, zapis_probki, adres_zapisu, adres_odczytu, adres_wsp,
    input  FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, wynik_valid, busy,
    input  blad_przepelnienia
  );
endinterface
`default_nettype wire

// File: rtl/fir_sterownik.sv
`default_nettype none
// ============================================================================
// Module   : fir_sterownik
// Brief    : Control FSM for one FIR output sample on a single MAC datapath
//            with a circular sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sterownik #(
  parameter int N_TAPS  = 16,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = $clog2(N_TAPS)
) (
  input  logic            clk_b,
  input  logic            rst_n,
  fir_sterownik_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ZAPIS       = 3'd1,
    S_MAC         = 3'd2,
    S_DRAIN       = 3'd3,
    S_ZAPIS_WYNIK = 3'd4,
    S_DONE        = 3'd5
  } stan_t;

  localparam logic [ADDR_W-1:0] c_ostatni = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W-1:0] c_jeden   = ADDR_W'(1);

  stan_t             r_stan;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_newest;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_adr_zap;
  logic [ADDR_W-1:0] r_adr_odcz;
  logic [ADDR_W-1:0] r_adr_wsp;
  logic              r_ready;
  logic              r_zapis;
  logic              r_reset_acc;
  logic              r_mac;
  logic              r_acc_zapis;
  logic              r_wynik_valid;
  logic              r_busy;
  logic              r_blad;
  logic              w_acc_en;

  // Outputs are registered: each transition loads the values of the state
  // being entered, so they line up with the state register.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_stan        <= S_IDLE;
      r_wr_ptr      <= '0;
      r_newest      <= '0;
      r_k           <= '0;
      r_adr_zap     <= '0;
      r_adr_odcz    <= '0;
      r_adr_wsp     <= '0;
      r_ready       <= 1'b1;
      r_zapis       <= 1'b0;
      r_reset_acc   <= 1'b0;
      r_mac         <= 1'b0;
      r_acc_zapis   <= 1'b0;
      r_wynik_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_blad        <= 1'b0;
    end else begin
      if (bus.probka_valid && (r_stan != S_IDLE)) begin
        r_blad <= 1'b1;
      end

      case (r_stan)
        S_IDLE: begin
          if (bus.probka_valid) begin
            r_stan      <= S_ZAPIS;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_zapis     <= 1'b1;
            r_reset_acc <= 1'b1;
            r_adr_zap   <= r_wr_ptr;
            r_newest    <= r_wr_ptr;
            r_wr_ptr    <= (r_wr_ptr == c_ostatni) ? '0 : r_wr_ptr + c_jeden;
          end
        end

        S_ZAPIS: begin
          r_stan      <= S_MAC;
          r_zapis     <= 1'b0;
          r_reset_acc <= 1'b0;
          r_mac       <= 1'b1;
          r_k         <= '0;
          r_adr_wsp   <= '0;
          r_adr_odcz  <= r_newest;
        end

        S_MAC: begin
          if (r_k == c_ostatni) begin
            r_mac <= 1'b0;
            if (MEM_LAT != 0) begin
              r_stan <= S_DRAIN;
            end else begin
              r_stan      <= S_ZAPIS_WYNIK;
              r_acc_zapis <= 1'b1;
            end
          end else begin
            r_k        <= r_k + c_jeden;
            r_adr_wsp  <= r_k + c_jeden;
            // Walk backwards through the circular buffer, newest sample first.
            r_adr_odcz <= (r_adr_odcz == '0) ? c_ostatni : r_adr_odcz - c_jeden;
          end
        end

        S_DRAIN: begin
          r_stan      <= S_ZAPIS_WYNIK;
          r_acc_zapis <= 1'b1;
        end

        S_ZAPIS_WYNIK: begin
          r_stan        <= S_DONE;
          r_acc_zapis   <= 1'b0;
          r_wynik_valid <= 1'b1;
        end

        S_DONE: begin
          r_stan        <= S_IDLE;
          r_wynik_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_ready       <= 1'b1;
        end

        default: begin
          r_stan <= S_IDLE;
        end
      endcase
    end
  end

  // Accumulator enable follows the MAC window, shifted by the read latency
  // so that it coincides with the data returned for each tap.
  generate
    if (MEM_LAT == 0) begin : g_bez_opoznienia
      assign w_acc_en = r_mac;
    end else begin : g_opoznienie
      logic r_mac_dl;

      always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
          r_mac_dl <= 1'b0;
        end else begin
          r_mac_dl <= r_mac;
        end
      end

      assign w_acc_en = r_mac_dl;
    end
  endgenerate

  assign bus.probka_ready       = r_ready;
  assign bus.zapis_probki       = r_zapis;
  assign bus.adres_zapisu       = r_adr_zap;
  assign bus.adres_odczytu      = r_adr_odcz;
  assign bus.adres_wsp          = r_adr_wsp;
  assign bus.FSM_reset_Acc      = r_reset_acc;
  assign bus.FSM_Acc_en         = w_acc_en;
  assign bus.FSM_Acc_zapis      = r_acc_zapis;
  assign bus.wynik_valid        = r_wynik_valid;
  assign bus.busy               = r_busy;
  assign bus.blad_przepelnienia = r_blad;

endmodule
`default_nettype wire

// File: tb/tb_fir_sterownik.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sterownik
// Brief    : Directed bench for fir_sterownik with a small MAC datapath model
//            around three controller configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_sterownik;

  logic clk_b = 1'b0;
  logic rst_n = 1'b0;
  logic pv [3];
  int   sel = 0;
  int   din = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_b = ~clk_b;

  fir_sterownik_if #(.ADDR_W(2)) if4 ();
  fir_sterownik_if #(.ADDR_W(3)) if5 ();
  fir_sterownik_if #(.ADDR_W(4)) if16 ();

  assign if4.probka_valid  = pv[0];
  assign if5.probka_valid  = pv[1];
  assign if16.probka_valid = pv[2];

  fir_sterownik #(.N_TAPS(4), .MEM_LAT(1), .ADDR_W(2)) u_dut4 (
    .clk_b(clk_b), .rst_n(rst_n), .bus(if4));
  fir_sterownik #(.N_TAPS(5), .MEM_LAT(0), .ADDR_W(3)) u_dut5 (
    .clk_b(clk_b), .rst_n(rst_n), .bus(if5));
  fir_sterownik #(.N_TAPS(16), .MEM_LAT(1), .ADDR_W(4)) u_dut16 (
    .clk_b(clk_b), .rst_n(rst_n), .bus(if16));

  // Datapath around the 4-tap controller: registered reads (latency 1).
  int mem4 [4]  = '{default: 0};
  int coef4 [4] = '{1, 2, 3, 4};
  int q4_s = 0, q4_c = 0, acc4 = 0, res4 = 0;

  always @(posedge clk_b) begin
    if (if4.zapis_probki) mem4[if4.adres_zapisu] <= din;
    q4_s <= mem4[if4.adres_odczytu];
    q4_c <= coef4[if4.adres_wsp];
    if (if4.FSM_reset_Acc) begin
      acc4 <= 0;
      res4 <= 0;
    end else begin
      if (if4.FSM_Acc_en)    acc4 <= acc4 + q4_s * q4_c;
      if (if4.FSM_Acc_zapis) res4 <= acc4;
    end
  end

  // Datapath around the 5-tap controller: combinational reads.
  int mem5 [5]  = '{default: 0};
  int coef5 [5] = '{1, 1, 1, 1, 1};
  int acc5 = 0, res5 = 0;

  always @(posedge clk_b) begin
    if (if5.zapis_probki) mem5[if5.adres_zapisu] <= din;
    if (if5.FSM_reset_Acc) begin
      acc5 <= 0;
      res5 <= 0;
    end else begin
      if (if5.FSM_Acc_en)    acc5 <= acc5 + mem5[if5.adres_odczytu] * coef5[if5.adres_wsp];
      if (if5.FSM_Acc_zapis) res5 <= acc5;
    end
  end

  logic m_ready, m_busy, m_zapis, m_rst_acc, m_en, m_zap, m_wv, m_blad;
  int   m_wr_adr, m_rd_adr, m_wsp, m_wynik;

  always_comb begin
    m_ready = if16.probka_ready;   m_busy = if16.busy;
    m_zapis = if16.zapis_probki;   m_rst_acc = if16.FSM_reset_Acc;
    m_en = if16.FSM_Acc_en;        m_zap = if16.FSM_Acc_zapis;
    m_wv = if16.wynik_valid;       m_blad = if16.blad_przepelnienia;
    m_wr_adr = int'(if16.adres_zapisu);
    m_rd_adr = int'(if16.adres_odczytu);
    m_wsp = int'(if16.adres_wsp);  m_wynik = 0;
    case (sel)
      0: begin
        m_ready = if4.probka_ready;   m_busy = if4.busy;
        m_zapis = if4.zapis_probki;   m_rst_acc = if4.FSM_reset_Acc;
        m_en = if4.FSM_Acc_en;        m_zap = if4.FSM_Acc_zapis;
        m_wv = if4.wynik_valid;       m_blad = if4.blad_przepelnienia;
        m_wr_adr = int'(if4.adres_zapisu);
        m_rd_adr = int'(if4.adres_odczytu);
        m_wsp = int'(if4.adres_wsp);  m_wynik = res4;
      end
      1: begin
        m_ready = if5.probka_ready;   m_busy = if5.busy;
        m_zapis = if5.zapis_probki;   m_rst_acc = if5.FSM_reset_Acc;
        m_en = if5.FSM_Acc_en;        m_zap = if5.FSM_Acc_zapis;
        m_wv = if5.wynik_valid;       m_blad = if5.blad_przepelnienia;
        m_wr_adr = int'(if5.adres_zapisu);
        m_rd_adr = int'(if5.adres_odczytu);
        m_wsp = int'(if5.adres_wsp);  m_wynik = res5;
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  int rd_seq [16];
  int wr_addr_obs, wynik_obs, wv_cycle, rdy_cycle;
  int en_cnt, en_first, en_last, overlap, wsp_bad, zap1;
  int ovf_before, ovf_after;

  // One sample transaction; cycle numbers count from the acceptance cycle.
  task automatic run_sample(input int dane, input int n, input int lat, input int ovf_c);
    int guard;
    guard = 0;
    @(negedge clk_b);
    while (!m_ready && guard < 200) begin
      @(negedge clk_b);
      guard++;
    end
    check_val("ready_before_sample", int'(m_ready), 1);
    din = dane;
    pv[sel] = 1'b1;
    en_cnt = 0; en_first = -1; en_last = -1; overlap = 0; wsp_bad = 0;
    wv_cycle = -1; wynik_obs = -1; rdy_cycle = -1; wr_addr_obs = -1; zap1 = 0;
    ovf_before = -1; ovf_after = -1;
    for (int c = 1; c <= n + 4 + lat; c++) begin
      @(negedge clk_b);
      if (c == 1) begin
        pv[sel] = 1'b0;
        wr_addr_obs = m_wr_adr;
        zap1 = int'(m_zapis && m_rst_acc);
      end
      if (ovf_c != 0 && c == ovf_c) begin
        ovf_before = int'(m_blad);
        pv[sel] = 1'b1;
      end
      if (ovf_c != 0 && c == ovf_c + 1) begin
        ovf_after = int'(m_blad);
        pv[sel] = 1'b0;
      end
      if (c >= 2 && c <= n + 1) begin
        rd_seq[c-2] = m_rd_adr;
        if (m_wsp != c - 2) wsp_bad++;
      end
      if (m_en) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (int'(m_rst_acc) + int'(m_en) + int'(m_zap) > 1) overlap++;
      if (m_wv && wv_cycle < 0) begin
        wv_cycle = c;
        wynik_obs = m_wynik;
      end
      if (m_ready && rdy_cycle < 0) rdy_cycle = c;
    end
    check_val("zapis_and_reset_acc_c1", zap1, 1);
    check_val("acc_en_count", en_cnt, n);
    check_val("acc_en_first", en_first, 2 + lat);
    check_val("acc_en_last", en_last, n + 1 + lat);
    check_val("wynik_valid_cycle", wv_cycle, n + 3 + lat);
    check_val("ready_again_cycle", rdy_cycle, n + 4 + lat);
    check_val("strobe_overlap", overlap, 0);
    check_val("adres_wsp_seq", wsp_bad, 0);
  endtask

  int imp_in [6]  = '{1, 0, 0, 0, 0, 0};
  int imp_exp [6] = '{1, 2, 3, 4, 0, 0};
  int st_exp [6]  = '{1, 2, 3, 4, 5, 5};
  int acc_c [4];
  int n_acc, wv_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0; pv[2] = 1'b0;
    repeat (3) @(negedge clk_b);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_val("rst_ready", int'(m_ready), 1);
      check_val("rst_busy", int'(m_busy), 0);
      check_val("rst_strobes", int'(m_zapis) + int'(m_rst_acc) + int'(m_en) + int'(m_zap) + int'(m_wv), 0);
      check_val("rst_blad", int'(m_blad), 0);
      check_val("rst_addr", m_wr_adr + m_rd_adr + m_wsp, 0);
    end
    @(negedge clk_b);
    rst_n = 1'b1;

    // Impulse response and circular wrap on the 4-tap, latency-1 controller
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      run_sample(imp_in[i], 4, 1, 0);
      check_val("imp_result", wynik_obs, imp_exp[i]);
      check_val("imp_wr_addr", wr_addr_obs, i % 4);
    end
    check_val("wrap_rd0", rd_seq[0], 1);
    check_val("wrap_rd1", rd_seq[1], 0);
    check_val("wrap_rd2", rd_seq[2], 3);
    check_val("wrap_rd3", rd_seq[3], 2);

    // Overflow: extra sample offered in cycle 3 is dropped
    run_sample(5, 4, 1, 3);
    check_val("ovf_result", wynik_obs, 5);
    check_val("ovf_flag_c3", ovf_before, 0);
    check_val("ovf_flag_c4", ovf_after, 1);
    repeat (5) @(negedge clk_b);
    check_val("ovf_flag_sticky", int'(m_blad), 1);

    // Reset during MAC at tap k=2 (cycle 4)
    @(negedge clk_b);
    din = 7;
    pv[0] = 1'b1;
    @(negedge clk_b);
    pv[0] = 1'b0;
    repeat (3) @(negedge clk_b);
    check_val("pre_rst_acc_en", int'(m_en), 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_acc_en", int'(m_en), 0);
    check_val("midrst_ready", int'(m_ready), 1);
    check_val("midrst_busy", int'(m_busy), 0);
    check_val("midrst_blad", int'(m_blad), 0);
    check_val("midrst_rd_addr", m_rd_adr, 0);
    @(negedge clk_b);
    rst_n = 1'b1;
    wv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_b);
      if (m_wv) wv_seen++;
    end
    check_val("aborted_no_wynik", wv_seen, 0);
    run_sample(2, 4, 1, 0);
    check_val("post_rst_wr_addr", wr_addr_obs, 0);
    check_val("post_rst_result", wynik_obs, 31);

    // Step input on the 5-tap, latency-0 controller
    sel = 1;
    for (int i = 0; i < 6; i++) begin
      run_sample(1, 5, 0, 0);
      check_val("step_result", wynik_obs, st_exp[i]);
      check_val("step_wr_addr", wr_addr_obs, i % 5);
      if (i == 1) begin
        check_val("step_rd_wrap_a", rd_seq[1], 0);
        check_val("step_rd_wrap_b", rd_seq[2], 4);
      end
    end

    // Back-to-back on the 16-tap controller with probka_valid held high
    sel = 2;
    @(negedge clk_b);
    pv[2] = 1'b1;
    n_acc = 0;
    overlap = 0;
    for (int c = 0; c < 90; c++) begin
      if (m_ready && n_acc < 4) begin
        acc_c[n_acc] = c;
        n_acc++;
      end
      if (int'(m_rst_acc) + int'(m_en) + int'(m_zap) > 1) overlap++;
      @(negedge clk_b);
    end
    pv[2] = 1'b0;
    check_val("b2b_accept_count", n_acc, 4);
    for (int i = 1; i < 4; i++) begin
      check_val("b2b_interval", acc_c[i] - acc_c[i-1], 21);
    end
    check_val("b2b_overlap", overlap, 0);
    check_val("b2b_overflow", int'(m_blad), 1);
    repeat (30) @(negedge clk_b);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_sterownik.md
# fir_sterownik

Control FSM for one FIR output sample computed in place on a single multiply-accumulate datapath. For each input sample it:
- writes the sample into a circular sample buffer;
- clears the accumulator;
- walks N_TAPS sample/coefficient address pairs;
- drives the accumulator enable, compensating for memory read latency;
- commands the result capture and flags the output as valid.

It drives `FSM_reset_Acc`, `FSM_Acc_en` and `FSM_Acc_zapis` of the accumulator stage and the address ports of the sample and coefficient memories.

## Interface

Parameters:
- N_TAPS, 16, number of filter taps (≥2, power of two not required)
- MEM_LAT, 1, read latency in cycles of sample/coefficient memories (0 or 1)
- ADDR_W, $clog2(N_TAPS), address width

Ports:
- clk_b  in  1  clock; single clock domain, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- probka_valid  in  1  new input sample present
- probka_ready  out  1  controller idle, sample accepted this cycle if probka_valid=1
- zapis_probki  out  1  write strobe of sample buffer
- adres_zapisu  out  ADDR_W  sample buffer write address
- adres_odczytu  out  ADDR_W  sample buffer read address
- adres_wsp  out  ADDR_W  coefficient memory read address
- FSM_reset_Acc  out  1  clear accumulator and result register
- FSM_Acc_en  out  1  load accumulator with current sum
- FSM_Acc_zapis  out  1  copy accumulator into result register
- wynik_valid  out  1  one-cycle pulse: result register holds new sample result
- busy  out  1  controller not in IDLE
- blad_przepelnienia  out  1  sticky: sample offered while busy and lost

## Operation

- States: IDLE, ZAPIS, MAC, DRAIN, ZAPIS_WYNIK, DONE.
- **IDLE**
  - probka_ready=1, busy=0.
  - probka_valid=1 → ZAPIS.
- **ZAPIS** (1 cycle)
  - zapis_probki=1 and FSM_reset_Acc=1.
  - adres_zapisu=wr_ptr.
  - Latch newest=wr_ptr.
  - wr_ptr advances, wrapping N_TAPS-1→0.
  - Next state: MAC.
- **MAC** (exactly N_TAPS cycles, tap counter k=0..N_TAPS-1)
  - adres_wsp=k.
  - adres_odczytu=(newest−k) mod N_TAPS, decremented with explicit wrap 0→N_TAPS-1.
  - After k=N_TAPS-1: go to DRAIN if MEM_LAT=1, otherwise ZAPIS_WYNIK.
- **FSM_Acc_en**: MAC-state indicator delayed by MEM_LAT register stages. It is high for exactly N_TAPS consecutive cycles, each aligned to the data read for tap k.
- **DRAIN** (MEM_LAT cycles): addresses hold, no new reads. Next state: ZAPIS_WYNIK.
- **ZAPIS_WYNIK** (1 cycle): FSM_Acc_zapis=1; FSM_Acc_en is guaranteed 0 in this cycle.
- **DONE** (1 cycle): wynik_valid=1. Next state: IDLE.
- **Mutual exclusion**: FSM_reset_Acc, FSM_Acc_en and FSM_Acc_zapis are never high in the same cycle.
- **Overflow**
  - probka_valid=1 in any state other than IDLE sets blad_przepelnienia; the sample is dropped and no queueing occurs.
  - The flag clears only on reset.
- **Addresses outside MAC/DRAIN**: hold their last value. Only zapis_probki qualifies writes.

## Timing

- Reset (asynchronous, any state, including mid-MAC):
  - State → IDLE; wr_ptr, newest, k and the delay line → 0.
  - Outputs: probka_ready=1, every other output 0, all addresses 0, blad_przepelnienia=0.
  - An aborted computation produces no wynik_valid.
- Acceptance cycle = cycle 0 (IDLE, probka_valid=1 at rising edge). Then:
  - cycle 1: ZAPIS
  - cycles 2..N_TAPS+1: MAC
  - FSM_Acc_en high in cycles 2+MEM_LAT..N_TAPS+1+MEM_LAT
  - cycle N_TAPS+2+MEM_LAT: FSM_Acc_zapis
  - cycle N_TAPS+3+MEM_LAT: wynik_valid
  - cycle N_TAPS+4+MEM_LAT: probka_ready=1 again
- Throughput: one sample per N_TAPS+4+MEM_LAT cycles.
- probka_valid held high continuously: a new sample is accepted in every IDLE cycle, back-to-back. Overflow is flagged in every busy cycle it remains high.
- All outputs are Moore functions of registered state; no combinational path from probka_valid to any output.

## Test plan

- **Impulse, N_TAPS=4, MEM_LAT=1**
  - Stimulus: coefficients {1,2,3,4}; samples 1,0,0,0,0.
  - Results: 1,2,3,4,0.
  - Each wynik_valid occurs in cycle 8 after its acceptance cycle; FSM_Acc_en is high for exactly 4 cycles per sample.
- **Circular wrap, N_TAPS=4**
  - Stimulus: 6 samples.
  - adres_zapisu sequence: 0,1,2,3,0,1.
  - For sample 6 (written at 1), adres_odczytu sequence in MAC: 1,0,3,2.
- **Non-power-of-two, N_TAPS=5, MEM_LAT=0**
  - Stimulus: step input of 1s; coefficients {1,1,1,1,1}.
  - Results: 1,2,3,4,5,5.
  - wynik_valid occurs in cycle 8; read address wraps 0→4.
- **Overflow**
  - Stimulus: probka_valid pulsed in cycle 3 after an acceptance.
  - blad_przepelnienia=1 from cycle 4 onward; the next result is unaffected; the flag persists until rst_n is asserted.
- **Reset mid-MAC**
  - Stimulus: rst_n asserted at tap k=2.
  - Immediately: FSM_Acc_en=0, probka_ready=1, busy=0.
  - Next sample after release is written at address 0 with the correct result.
- **Back-to-back**
  - Stimulus: probka_valid held high, N_TAPS=16, MEM_LAT=1.
  - Acceptances every 21 cycles; control strobes never overlap.
